matrix_alu: RTL and testbench

Memory-mapped 4x4 matrix arithmetic unit on the execution engine's shared bus, directly downstream of the engine. The engine writes two operand matrices and a command word, then reads back the result matrix. Computation is element-serial, one element per clock, and runs behind a busy/done/error status register. Replaces the engine's in-line pseudo-ALU for the matrix opcodes.

---
 rtl/matrix_pkg.sv | 37 +++
 rtl/matrix_elem_unit.sv | 83 ++++++++
 rtl/matrix_alu.sv | 194 +++++++++++++++++++
 tb/tb_matrix_alu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants for the memory-mapped 4x4 matrix ALU.
//   - opcode values carried in CMD[7:0]
//   - register offsets relative to the bus base address
//   - FSM state type, STATUS bit positions, default geometry
// Optional feature macro: MATRIX_SAT_EN (used by matrix_elem_unit).
package matrix_pkg;

  localparam int unsigned ELEM_W_DEF = 16;
  localparam int unsigned DIM_DEF    = 4;

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_TRANS = 8'h03;
  localparam logic [7:0] OP_SCALE = 8'h04;

  localparam logic [2:0] REG_SRC1   = 3'd0;
  localparam logic [2:0] REG_SRC2   = 3'd1;
  localparam logic [2:0] REG_RESULT = 3'd2;
  localparam logic [2:0] REG_CMD    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam int unsigned NUM_REGS  = 5;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_ERR  = 2;
  localparam int unsigned ST_SAT  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } state_e;

  function automatic logic op_valid(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_TRANS) || (op == OP_SCALE);
  endfunction

endpackage

// File: rtl/matrix_elem_unit.sv
// matrix_elem_unit: combinational single-element operation.
// Ports:
//   op_i  [7:0]        opcode (add/sub/transpose/scale)
//   a_i   [ELEM_W-1:0] source-1 element (already transpose-selected)
//   b_i   [ELEM_W-1:0] source-2 element (or scalar for scale)
//   res_o [ELEM_W-1:0] result element
//   sat_o              result was clamped (only with MATRIX_SAT_EN)
// MATRIX_SAT_EN defined: add/sub/scale saturate to the signed range.
// MATRIX_SAT_EN undefined: wrap-around arithmetic, sat_o tied low.
module matrix_elem_unit
  import matrix_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF
) (
  input  logic [7:0]        op_i,
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  output logic [ELEM_W-1:0] res_o,
  output logic              sat_o
);

`ifdef MATRIX_SAT_EN
  localparam logic [ELEM_W-1:0] MAXV = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] MINV = {1'b1, {(ELEM_W-1){1'b0}}};

  logic [ELEM_W:0]     sum_w;
  logic [ELEM_W:0]     dif_w;
  logic [2*ELEM_W-1:0] prod_w;
  logic                prod_ovf;

  assign sum_w  = {a_i[ELEM_W-1], a_i} + {b_i[ELEM_W-1], b_i};
  assign dif_w  = {a_i[ELEM_W-1], a_i} - {b_i[ELEM_W-1], b_i};
  assign prod_w = $signed(a_i) * $signed(b_i);
  // Product fits iff the bits above the result's sign bit are a pure sign extension.
  assign prod_ovf = (prod_w[2*ELEM_W-1:ELEM_W-1] != '0) &&
                    (prod_w[2*ELEM_W-1:ELEM_W-1] != '1);

  always_comb begin
    res_o = a_i;
    sat_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        if (sum_w[ELEM_W] != sum_w[ELEM_W-1]) begin
          sat_o = 1'b1;
          res_o = sum_w[ELEM_W] ? MINV : MAXV;
        end else begin
          res_o = sum_w[ELEM_W-1:0];
        end
      end
      OP_SUB: begin
        if (dif_w[ELEM_W] != dif_w[ELEM_W-1]) begin
          sat_o = 1'b1;
          res_o = dif_w[ELEM_W] ? MINV : MAXV;
        end else begin
          res_o = dif_w[ELEM_W-1:0];
        end
      end
      OP_SCALE: begin
        if (prod_ovf) begin
          sat_o = 1'b1;
          res_o = prod_w[2*ELEM_W-1] ? MINV : MAXV;
        end else begin
          res_o = prod_w[ELEM_W-1:0];
        end
      end
      default: res_o = a_i;
    endcase
  end
`else
  always_comb begin
    res_o = a_i;
    sat_o = 1'b0;
    case (op_i)
      OP_ADD:   res_o = a_i + b_i;
      OP_SUB:   res_o = a_i - b_i;
      // Low ELEM_W bits of a product are identical for signed and unsigned operands.
      OP_SCALE: res_o = a_i * b_i;
      default:  res_o = a_i;
    endcase
  end
`endif

endmodule

// File: rtl/matrix_alu.sv
// matrix_alu: memory-mapped 4x4 matrix arithmetic unit, element-serial.
// Ports:
//   Clk            system clock, all state on rising edge
//   Reset          synchronous reset, active-high
//   nRead          bus read strobe, active-low
//   nWrite         bus write strobe, active-low
//   address [15:0] bus address (registers at BASE_ADDR+0..+4)
//   ExeDataOut     write data from the execution engine
//   MatrixDataOut  registered read data, held until the next decoded read
//   Busy           high while a computation is in progress (STATUS bit0)
// Register map: +0 SRC1 (W), +1 SRC2 (W), +2 RESULT (R), +3 CMD (W),
// +4 STATUS (R: bit0 busy, bit1 done, bit2 error, bit3 saturated).
// MATRIX_SAT_EN selects saturating arithmetic inside matrix_elem_unit;
// without it the saturation flag never fires and STATUS bit3 reads 0.
module matrix_alu
  import matrix_pkg::*;
#(
  parameter logic [15:0]  BASE_ADDR = 16'h2010,
  parameter int unsigned  ELEM_W    = ELEM_W_DEF,
  parameter int unsigned  DIM       = DIM_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      nRead,
  input  logic                      nWrite,
  input  logic [15:0]               address,
  input  logic [DIM*DIM*ELEM_W-1:0] ExeDataOut,
  output logic [DIM*DIM*ELEM_W-1:0] MatrixDataOut,
  output logic                      Busy
);

  localparam int unsigned N     = DIM * DIM;
  localparam int unsigned DW    = N * ELEM_W;
  localparam int unsigned IDX_W = $clog2(N);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     src1_q, src1_d;
  logic [DW-1:0]     src2_q, src2_d;
  logic [DW-1:0]     work_q, work_d;
  logic [DW-1:0]     result_q, result_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              sat_q, sat_d;

  logic              busy;
  logic [15:0]       offset;
  logic              in_map;
  logic [2:0]        reg_sel;
  logic              bus_wr, bus_rd, bus_clash;
  logic [7:0]        cmd_op;
  logic [DW-1:0]     status;

  logic [IDX_W-1:0]  trans_idx;
  logic [IDX_W-1:0]  a_idx;
  logic [ELEM_W-1:0] elem_a, elem_b, elem_res;
  logic              elem_sat;

  assign busy = (state_q == COMPUTE);
  assign Busy = busy;
  assign MatrixDataOut = rdata_q;

  assign offset    = address - BASE_ADDR;
  assign in_map    = (offset < 16'(NUM_REGS));
  assign reg_sel   = offset[2:0];
  assign bus_wr    = !nWrite && nRead;
  assign bus_rd    = !nRead && nWrite;
  assign bus_clash = !nRead && !nWrite;
  assign cmd_op    = ExeDataOut[7:0];

  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
    status[ST_SAT]  = sat_q;
  end

  // Result element (row, col) comes from source element (col, row).
  assign trans_idx = IDX_W'((int'(idx_q) % DIM) * DIM + int'(idx_q) / DIM);
  assign a_idx     = (op_q == OP_TRANS) ? trans_idx : idx_q;
  assign elem_a    = src1_q[a_idx*ELEM_W +: ELEM_W];
  assign elem_b    = (op_q == OP_SCALE) ? src2_q[ELEM_W-1:0] : src2_q[idx_q*ELEM_W +: ELEM_W];

  matrix_elem_unit #(
    .ELEM_W (ELEM_W)
  ) u_elem (
    .op_i  (op_q),
    .a_i   (elem_a),
    .b_i   (elem_b),
    .res_o (elem_res),
    .sat_o (elem_sat)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    work_d   = work_q;
    result_d = result_q;
    rdata_d  = rdata_q;
    done_d   = done_q;
    err_d    = err_q;
    sat_d    = sat_q;

    if (in_map) begin
      if (bus_clash) begin
        err_d = 1'b1;
      end else if (bus_wr) begin
        case (reg_sel)
          REG_SRC1: begin
            if (busy) err_d = 1'b1;
            else      src1_d = ExeDataOut;
          end
          REG_SRC2: begin
            if (busy) err_d = 1'b1;
            else      src2_d = ExeDataOut;
          end
          REG_CMD: begin
            if (busy) begin
              err_d = 1'b1;
            end else if (op_valid(cmd_op)) begin
              op_d    = cmd_op;
              idx_d   = '0;
              done_d  = 1'b0;
              state_d = COMPUTE;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (bus_rd) begin
        case (reg_sel)
          REG_RESULT: rdata_d = result_q;
          REG_STATUS: begin
            rdata_d = status;
            done_d  = 1'b0;
            err_d   = 1'b0;
            sat_d   = 1'b0;
          end
          default: rdata_d = '0;
        endcase
      end
    end

    // Placed after the bus decode so a completion or saturation on the
    // same edge as a STATUS read survives the read-clear.
    if (state_q == COMPUTE) begin
      work_d[idx_q*ELEM_W +: ELEM_W] = elem_res;
      if (elem_sat) sat_d = 1'b1;
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_W'(N - 1)) begin
        result_d = work_d;
        done_d   = 1'b1;
        idx_d    = '0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      idx_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      work_q   <= work_d;
      result_q <= result_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_matrix_alu.sv
module tb_matrix_alu;

  localparam logic [15:0] BASE = 16'h2010;

  logic         Clk;
  logic         Reset;
  logic         nRead;
  logic         nWrite;
  logic [15:0]  address;
  logic [255:0] ExeDataOut;
  logic [255:0] MatrixDataOut;
  logic         Busy;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  matrix_alu #(
    .BASE_ADDR (16'h2010),
    .ELEM_W    (16),
    .DIM       (4)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .nRead         (nRead),
    .nWrite        (nWrite),
    .address       (address),
    .ExeDataOut    (ExeDataOut),
    .MatrixDataOut (MatrixDataOut),
    .Busy          (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [255:0] ramp(input int mult, input int add);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(i * mult + add);
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [255:0] d);
    @(negedge Clk);
    address    = BASE + 16'(off);
    ExeDataOut = d;
    nWrite     = 1'b0;
    @(posedge Clk);
    #1;
    nWrite = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] off);
    @(negedge Clk);
    address = BASE + 16'(off);
    nRead   = 1'b0;
    @(posedge Clk);
    #1;
    nRead = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [255:0] exp_v;

  initial begin
    Reset = 1'b1; nRead = 1'b1; nWrite = 1'b1; address = 16'h0000; ExeDataOut = '0;
    wait_cycles(2);
    @(negedge Clk) Reset = 1'b0;
    check("reset_busy", {255'd0, Busy}, 256'd0);
    check("reset_rdata", MatrixDataOut, 256'd0);
    bus_read(3'd4);
    check("reset_status", MatrixDataOut, 256'd0);

    // Add: element i = i + 100, Busy high for exactly 16 edges.
    bus_write(3'd0, ramp(1, 0));
    bus_write(3'd1, fill(16'd100));
    bus_write(3'd3, 256'h01);
    check("add_busy_start", {255'd0, Busy}, 256'd1);
    wait_cycles(15);
    check("add_busy_edge15", {255'd0, Busy}, 256'd1);
    wait_cycles(1);
    check("add_busy_edge16", {255'd0, Busy}, 256'd0);
    bus_read(3'd2);
    check("add_result", MatrixDataOut, ramp(1, 100));
    bus_read(3'd4);
    check("add_status_done", MatrixDataOut, 256'h2);
    bus_read(3'd4);
    check("add_status_cleared", MatrixDataOut, 256'h0);

    // Sub at the negative limit.
    bus_write(3'd0, fill(16'h8000));
    bus_write(3'd1, fill(16'h0001));
    bus_write(3'd3, 256'h02);
    wait_cycles(16);
    check("sub_busy_end", {255'd0, Busy}, 256'd0);
    bus_read(3'd2);
`ifdef MATRIX_SAT_EN
    check("sub_result_sat", MatrixDataOut, fill(16'h8000));
    bus_read(3'd4);
    check("sub_status_sat", MatrixDataOut, 256'hA);
`else
    check("sub_result_wrap", MatrixDataOut, fill(16'h7FFF));
    bus_read(3'd4);
    check("sub_status", MatrixDataOut, 256'h2);
`endif

    // Transpose of the ramp matrix.
    bus_write(3'd0, ramp(1, 0));
    bus_write(3'd3, 256'h03);
    wait_cycles(16);
    bus_read(3'd2);
    exp_v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_v[(r*4+c)*16 +: 16] = 16'(c*4 + r);
    check("trans_result", MatrixDataOut, exp_v);
    check("trans_e1", {240'd0, MatrixDataOut[1*16 +: 16]}, 256'd4);
    check("trans_e4", {240'd0, MatrixDataOut[4*16 +: 16]}, 256'd1);
    check("trans_e14", {240'd0, MatrixDataOut[14*16 +: 16]}, 256'd11);
    check("trans_e15", {240'd0, MatrixDataOut[15*16 +: 16]}, 256'd15);
    bus_read(3'd4);
    check("trans_status", MatrixDataOut, 256'h2);

    // Scale by S2 element 0 only; mid-computation read sees the old result.
    exp_v = fill(16'd7);
    exp_v[15:0] = 16'd3;
    bus_write(3'd1, exp_v);
    bus_write(3'd3, 256'h04);
    wait_cycles(7);
    bus_read(3'd2);
    exp_v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_v[(r*4+c)*16 +: 16] = 16'(c*4 + r);
    check("scale_mid_old_result", MatrixDataOut, exp_v);
    check("scale_mid_busy", {255'd0, Busy}, 256'd1);
    wait_cycles(8);
    check("scale_busy_end", {255'd0, Busy}, 256'd0);
    bus_read(3'd2);
    check("scale_result", MatrixDataOut, ramp(3, 0));
    bus_read(3'd4);
    check("scale_status", MatrixDataOut, 256'h2);

    // Invalid opcode.
    bus_write(3'd3, 256'h07);
    check("badop_busy", {255'd0, Busy}, 256'd0);
    bus_read(3'd4);
    check("badop_status", MatrixDataOut, 256'h4);

    // SRC1 write while busy is rejected.
    bus_write(3'd0, fill(16'd5));
    bus_write(3'd1, fill(16'd100));
    bus_write(3'd3, 256'h01);
    wait_cycles(3);
    bus_write(3'd0, fill(16'h1000));
    check("busywr_still_busy", {255'd0, Busy}, 256'd1);
    wait_cycles(12);
    check("busywr_busy_end", {255'd0, Busy}, 256'd0);
    bus_read(3'd2);
    check("busywr_result", MatrixDataOut, fill(16'd105));
    bus_read(3'd4);
    check("busywr_status", MatrixDataOut, 256'h6);

    // Both strobes low: no access, error set.
    @(negedge Clk);
    address    = BASE;
    ExeDataOut = fill(16'h1234);
    nRead      = 1'b0;
    nWrite     = 1'b0;
    @(posedge Clk);
    #1;
    nRead  = 1'b1;
    nWrite = 1'b1;
    check("clash_rdata_held", MatrixDataOut, 256'h6);
    bus_read(3'd4);
    check("clash_status", MatrixDataOut, 256'h4);
    bus_write(3'd3, 256'h03);
    wait_cycles(16);
    bus_read(3'd2);
    check("clash_src1_kept", MatrixDataOut, fill(16'd5));
    bus_read(3'd4);
    check("clash_status_after", MatrixDataOut, 256'h2);

    // Reset in the middle of a computation.
    bus_write(3'd3, 256'h01);
    wait_cycles(4);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_mid_busy", {255'd0, Busy}, 256'd0);
    check("rst_mid_rdata", MatrixDataOut, 256'd0);
    @(negedge Clk) Reset = 1'b0;
    bus_read(3'd4);
    check("rst_mid_status", MatrixDataOut, 256'd0);
    bus_read(3'd2);
    check("rst_mid_result", MatrixDataOut, 256'd0);
    bus_write(3'd0, ramp(1, 0));
    bus_write(3'd1, fill(16'd100));
    bus_write(3'd3, 256'h01);
    check("rst_fresh_busy", {255'd0, Busy}, 256'd1);
    wait_cycles(16);
    check("rst_fresh_busy_end", {255'd0, Busy}, 256'd0);
    bus_read(3'd2);
    check("rst_fresh_result", MatrixDataOut, ramp(1, 100));
    bus_read(3'd4);
    check("rst_fresh_status", MatrixDataOut, 256'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
